// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b - bin controller around one full-subtractor cell
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             ai, bi, d, bo;
    logic [WIDTH-1:0] r_next;

    // Shared full-subtractor cell; the new bit lands in the MSB so the LSB-first
    // stream ends up in place after WIDTH shifts.
    always_comb begin
        ai     = a_sh[0];
        bi     = b_sh[0];
        d      = ai ^ bi ^ br;
        bo     = (~ai & bi) | (~(ai ^ bi) & br);
        r_next = (r_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_next;
                    br   <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= r_next;
                        bout  <= bo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation: start sampled at the edge after this negedge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] exp_d, input logic exp_bo, input string tag);
        int n, busy_cnt;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy8), 32'd1);
        n = 0;
        busy_cnt = 1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done8) break;
            if (busy8) busy_cnt++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_diff"}, 32'(diff8), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout8), 32'(exp_bo));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
    endtask

    logic [7:0] tt_d, tt_bo;

    initial begin
        int n, gap;
        logic [7:0] hold_d;
        logic       hold_bo;
        logic [2:0] idx;
        bit seen_done;

        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        chk("rst_bout8", 32'(bout8), 32'd0);
        chk("rst_diff1", 32'(diff1), 32'd0);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "op5a3c");
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "op0001");
        op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "op100f");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "opffff");

        // WIDTH=1 full-subtractor truth table indexed by {a,b,bin}
        tt_d  = 8'b1001_0110;
        tt_bo = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            @(negedge clk);
            a1 = idx[2]; b1 = idx[1]; bin1 = idx[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            n = 0;
            while (n < 10) begin
                @(negedge clk);
                n++;
                if (done1) break;
            end
            chk($sformatf("w1_lat_%0d", i), 32'(n), 32'd1);
            chk($sformatf("w1_d_%0d", i), 32'(diff1), 32'(tt_d[i]));
            chk($sformatf("w1_bo_%0d", i), 32'(bout1), 32'(tt_bo[i]));
        end

        // start held high, operands change after capture
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done8) break;
        end
        chk("hold_lat", 32'(n), 32'd8);
        chk("hold_diff1", 32'(diff8), 32'h22);
        chk("hold_bout1", 32'(bout8), 32'd0);
        gap = 0;
        while (gap < 40) begin
            @(negedge clk);
            gap++;
            if (done8) break;
        end
        chk("hold_gap", 32'(gap), 32'd10);
        chk("hold_diff2", 32'(diff8), 32'hFF);
        chk("hold_bout2", 32'(bout8), 32'd0);
        start8 = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid-RUN
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_bout", 32'(bout8), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "op8001");

        // outputs hold while idle with toggling operands
        hold_d = 8'h7F;
        hold_bo = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            if (diff8 !== hold_d || bout8 !== hold_bo || busy8 !== 1'b0 || done8 !== 1'b0)
                seen_done = 1'b1;
        end
        chk("idle_stable", 32'(seen_done), 32'd0);
        chk("idle_diff", 32'(diff8), 32'(hold_d));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
